alu_resp_packer: RTL and testbench

Transmit-side framer for the UART ALU. Takes one ALU result (opcode plus RESULT_BYTES of data) over a valid/ready input and serializes it into a fixed-length byte frame on an AXI-stream byte output that drives `uart_tx` `s_axis_*`. It is the response counterpart to the receive-side command parser fed by `uart_rx`.

---
 rtl/alu_uart_pkg.sv | 17 +
 rtl/alu_resp_packer.sv | 131 +++++++++++++
 tb/tb_alu_resp_packer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_uart_pkg.sv
// Shared constants and types for the UART ALU command parser and response packer.
package alu_uart_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_OP   = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } resp_state_e;

endpackage

// File: rtl/alu_resp_packer.sv
// Serializes one ALU result into a SYNC/op/data/checksum byte frame on an AXI-stream byte port.
module alu_resp_packer
    import alu_uart_pkg::*;
#(
    parameter int unsigned       RESULT_BYTES = 4,
    parameter logic [BYTE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OP_W-1:0]              s_res_op,
    input  logic [BYTE_W*RESULT_BYTES-1:0] s_res_data,
    input  logic                         s_res_valid,
    output logic                         s_res_ready,
    output logic [BYTE_W-1:0]            m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         busy,
    output logic [15:0]                  frame_count
);

    localparam int unsigned DATA_W   = BYTE_W * RESULT_BYTES;
    localparam int unsigned IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESULT_BYTES - 1);

    resp_state_e           state_q, state_d;
    logic [BYTE_W-1:0]     tdata_q, tdata_d;
    logic                  tvalid_q;
    logic [OP_W-1:0]       op_q, op_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [BYTE_W-1:0]     csum_q, csum_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           count_q, count_d;
    logic                  ready_en_q;
    logic                  accept;
    logic                  hs;

    assign s_res_ready   = ready_en_q && (state_q == ST_IDLE);
    assign accept        = s_res_valid && s_res_ready;
    assign hs            = tvalid_q && m_axis_tready;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_count   = count_q;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            op_q       <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= (state_d != ST_IDLE);
            op_q       <= op_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state logic: every transition past IDLE waits on a byte handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_SYNC;
            ST_SYNC: if (hs)     state_d = ST_OP;
            ST_OP:   if (hs)     state_d = ST_DATA;
            ST_DATA: if (hs && (idx_q == LAST_IDX)) state_d = ST_CSUM;
            ST_CSUM: if (hs)     state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic: the next byte is loaded on each handshake, folding
    // data bytes into the checksum as they enter the output register.
    always_comb begin
        tdata_d = tdata_q;
        op_d    = op_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tdata_d = SYNC_BYTE;
                    op_d    = s_res_op;
                    shift_d = s_res_data;
                    csum_d  = s_res_op;
                    idx_d   = '0;
                end
            end
            ST_SYNC: begin
                if (hs) tdata_d = op_q;
            end
            ST_OP: begin
                if (hs) begin
                    tdata_d = shift_q[BYTE_W-1:0];
                    csum_d  = csum_q ^ shift_q[BYTE_W-1:0];
                    shift_d = shift_q >> BYTE_W;
                end
            end
            ST_DATA: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        tdata_d = csum_q;
                    end else begin
                        tdata_d = shift_q[BYTE_W-1:0];
                        csum_d  = csum_q ^ shift_q[BYTE_W-1:0];
                        shift_d = shift_q >> BYTE_W;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (hs) count_d = count_q + 16'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_resp_packer.sv
// Directed bench for alu_resp_packer: frame content, timing, backpressure, reset and counter wrap.
module tb_alu_resp_packer;

    logic        clk;
    logic        rst;

    logic [7:0]  res_op;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        busy;
    logic [15:0] fcount;

    logic [7:0]  s1_op;
    logic [7:0]  s1_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [7:0]  s1_tdata;
    logic        s1_tvalid;
    logic        s1_tready;
    logic        s1_busy;
    logic [15:0] s1_count;

    int checks;
    int fails;
    int exp_count;

    alu_resp_packer #(.RESULT_BYTES(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst),
        .s_res_op(res_op), .s_res_data(res_data), .s_res_valid(res_valid), .s_res_ready(res_ready),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .busy(busy), .frame_count(fcount)
    );

    alu_resp_packer #(.RESULT_BYTES(1), .SYNC_BYTE(8'hA5)) dut1 (
        .clk(clk), .rst(rst),
        .s_res_op(s1_op), .s_res_data(s1_data), .s_res_valid(s1_valid), .s_res_ready(s1_ready),
        .m_axis_tdata(s1_tdata), .m_axis_tvalid(s1_tvalid), .m_axis_tready(s1_tready),
        .busy(s1_busy), .frame_count(s1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [55:0] exp_frame(input logic [7:0] op, input logic [31:0] d);
        logic [7:0] cs;
        cs = op ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
        return {8'hA5, op, d[7:0], d[15:8], d[23:16], d[31:24], cs};
    endfunction

    // Offers a result at a negedge; returns at the negedge where SYNC is first visible.
    task automatic send_result(input logic [7:0] op, input logic [31:0] d, output bit tmo);
        res_op = op; res_data = d; res_valid = 1'b1; tmo = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (res_ready) break;
            @(negedge clk);
        end
        if (!res_ready) tmo = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        res_op    = 8'($urandom);
        res_data  = $urandom;
    endtask

    // Receives one 7-byte frame; returns at the negedge after the last handshake.
    task automatic collect(input int duty, output logic [55:0] got, output int cycles,
                           output int busy_cnt, output int rdy_cnt, output int viol, output bit tmo);
        int n;
        logic prev_stall;
        logic [7:0] prev_data;
        n = 0; cycles = 0; busy_cnt = 0; rdy_cnt = 0; viol = 0; tmo = 1'b0;
        got = '0; prev_stall = 1'b0; prev_data = '0;
        while (n < 7) begin
            if (cycles >= 2000) begin
                tmo = 1'b1;
                break;
            end
            cycles++;
            if (busy) busy_cnt++;
            if (res_ready) rdy_cnt++;
            if (prev_stall && (tvalid !== 1'b1 || tdata !== prev_data)) viol++;
            tready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < 32'(duty));
            if (tvalid && tready) begin
                got = {got[47:0], tdata};
                n++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = tvalid;
                prev_data  = tdata;
            end
            @(negedge clk);
        end
        tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if ({tvalid, tdata, res_ready, busy, fcount} !== 27'd0) begin
            fails++;
            $display("FAIL reset_state: got tvalid=%b tdata=%h ready=%b busy=%b count=%h, want all zero",
                     tvalid, tdata, res_ready, busy, fcount);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (res_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %b want 0", res_ready);
        end
        @(negedge clk);
        checks++;
        if (res_ready !== 1'b1 || s1_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_edge: got %b/%b want 1/1", res_ready, s1_ready);
        end
    endtask

    task automatic test_basic_frame();
        logic [55:0] got; int cyc, bc, rc, viol; bit tmo, stmo;
        send_result(8'h01, 32'h12345678, stmo);
        collect(100, got, cyc, bc, rc, viol, tmo);
        exp_count++;
        checks++;
        if (stmo || tmo || got !== 56'hA5_01_78_56_34_12_09) begin
            fails++;
            $display("FAIL basic_frame: got %h want a50178563412 09 (tmo=%b/%b)", got, stmo, tmo);
        end
        checks++;
        if (cyc !== 7 || bc !== 7) begin
            fails++;
            $display("FAIL basic_timing: got cycles=%0d busy=%0d want 7/7", cyc, bc);
        end
        checks++;
        if (busy !== 1'b0 || res_ready !== 1'b1 || tvalid !== 1'b0 || fcount !== 16'(exp_count)) begin
            fails++;
            $display("FAIL basic_bubble: got busy=%b ready=%b tvalid=%b count=%0d want 0/1/0/%0d",
                     busy, res_ready, tvalid, fcount, exp_count);
        end
    endtask

    task automatic test_all_ones();
        logic [55:0] got; int cyc, bc, rc, viol; bit tmo, stmo;
        send_result(8'hFF, 32'hFFFFFFFF, stmo);
        collect(100, got, cyc, bc, rc, viol, tmo);
        exp_count++;
        checks++;
        if (stmo || tmo || got !== 56'hA5_FF_FF_FF_FF_FF_FF) begin
            fails++;
            $display("FAIL all_ones: got %h want a5ffffffffffff", got);
        end
        checks++;
        if (fcount !== 16'(exp_count)) begin
            fails++;
            $display("FAIL all_ones_count: got %0d want %0d", fcount, exp_count);
        end
    endtask

    task automatic test_random_backpressure();
        logic [55:0] got, exp; int cyc, bc, rc, viol; bit tmo, stmo;
        logic [7:0] op; logic [31:0] d;
        int bad_frames, bad_viol;
        bad_frames = 0; bad_viol = 0;
        for (int f = 0; f < 100; f++) begin
            op = 8'($urandom);
            d  = $urandom;
            exp = exp_frame(op, d);
            send_result(op, d, stmo);
            collect(30, got, cyc, bc, rc, viol, tmo);
            exp_count++;
            checks++;
            if (stmo || tmo || got !== exp) begin
                fails++;
                bad_frames++;
                $display("FAIL random_frame[%0d]: got %h want %h", f, got, exp);
            end
            bad_viol += viol;
        end
        checks++;
        if (bad_viol !== 0) begin
            fails++;
            $display("FAIL stall_stability: got %0d violations want 0", bad_viol);
        end
        checks++;
        if (fcount !== 16'(exp_count)) begin
            fails++;
            $display("FAIL random_count: got %0d want %0d", fcount, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] got; int cyc, bc, rc, viol; bit tmo;
        res_op = 8'h3C; res_data = 32'hDEADBEEF; res_valid = 1'b1;
        @(negedge clk);
        res_op = 8'h5A; res_data = 32'h0BADF00D;
        collect(100, got, cyc, bc, rc, viol, tmo);
        exp_count++;
        checks++;
        if (tmo || got !== 56'hA5_3C_EF_BE_AD_DE_1E || rc !== 0) begin
            fails++;
            $display("FAIL b2b_first: got %h ready_cycles=%0d want a53cefbeadde1e/0", got, rc);
        end
        checks++;
        if (res_ready !== 1'b1 || tvalid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: got ready=%b tvalid=%b want 1/0", res_ready, tvalid);
        end
        @(negedge clk);
        res_valid = 1'b0;
        collect(100, got, cyc, bc, rc, viol, tmo);
        exp_count++;
        checks++;
        if (tmo || got !== exp_frame(8'h5A, 32'h0BADF00D) || cyc !== 7) begin
            fails++;
            $display("FAIL b2b_second: got %h cycles=%0d want %h/7", got, cyc, exp_frame(8'h5A, 32'h0BADF00D));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [55:0] got; int cyc, bc, rc, viol; bit tmo, stmo;
        tready = 1'b1;
        send_result(8'h55, 32'h11223344, stmo);
        repeat (3) @(negedge clk);
        checks++;
        if (stmo || tvalid !== 1'b1 || tdata !== 8'h33) begin
            fails++;
            $display("FAIL mid_frame_d1: got tvalid=%b tdata=%h want 1/33", tvalid, tdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: got tvalid=%b busy=%b ready=%b want 0/0/0", tvalid, busy, res_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_count = 0;
        @(negedge clk);
        checks++;
        if (fcount !== 16'd0 || res_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_recover: got count=%0d ready=%b want 0/1", fcount, res_ready);
        end
        send_result(8'hC3, 32'hA1B2C3D4, stmo);
        collect(100, got, cyc, bc, rc, viol, tmo);
        exp_count++;
        checks++;
        if (stmo || tmo || got !== exp_frame(8'hC3, 32'hA1B2C3D4) || fcount !== 16'(exp_count)) begin
            fails++;
            $display("FAIL post_reset_frame: got %h count=%0d want %h/%0d",
                     got, fcount, exp_frame(8'hC3, 32'hA1B2C3D4), exp_count);
        end
    endtask

    task automatic test_counter_wrap();
        logic [55:0] got; int cyc, bc, rc, viol; bit tmo, stmo;
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        @(negedge clk);
        checks++;
        if (fcount !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_preload: got %h want ffff", fcount);
        end
        send_result(8'h10, 32'h00000001, stmo);
        collect(100, got, cyc, bc, rc, viol, tmo);
        checks++;
        if (stmo || tmo || fcount !== 16'h0000 || got !== exp_frame(8'h10, 32'h00000001)) begin
            fails++;
            $display("FAIL wrap_count: got count=%h frame=%h want 0000/%h", fcount, got, exp_frame(8'h10, 32'h00000001));
        end
    endtask

    task automatic test_small_frame();
        logic [31:0] got; int n, cyc;
        force dut1.count_q = 16'hFFFF;
        #1;
        release dut1.count_q;
        @(negedge clk);
        s1_tready = 1'b1;
        s1_op = 8'h0F; s1_data = 8'hF0; s1_valid = 1'b1;
        @(negedge clk);
        s1_valid = 1'b0; s1_op = 8'h00; s1_data = 8'h00;
        got = '0; n = 0; cyc = 0;
        while (n < 4 && cyc < 50) begin
            cyc++;
            if (s1_tvalid && s1_tready) begin
                got = {got[23:0], s1_tdata};
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 32'hA5_0F_F0_FF || cyc !== 4) begin
            fails++;
            $display("FAIL small_frame: got %h cycles=%0d want a50ff0ff/4", got, cyc);
        end
        checks++;
        if (s1_count !== 16'h0000 || s1_busy !== 1'b0) begin
            fails++;
            $display("FAIL small_wrap: got count=%h busy=%b want 0000/0", s1_count, s1_busy);
        end
    endtask

    initial begin
        checks = 0; fails = 0; exp_count = 0;
        rst = 1'b0;
        res_op = '0; res_data = '0; res_valid = 1'b0; tready = 1'b1;
        s1_op = '0; s1_data = '0; s1_valid = 1'b0; s1_tready = 1'b1;
        test_reset();
        test_basic_frame();
        test_all_ones();
        test_random_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_counter_wrap();
        test_small_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
